// File: rtl/jtkiwi_tilescan_pkg.sv
// Shared tile-layer constants: line geometry and tile RAM word layout.
// The scanner and the tile drawer both import this package.
package jtkiwi_tilescan_pkg;
  localparam logic [5:0] NTILES  = 6'd32;  // tiles per line
  localparam int         TILE_W  = 16;     // pixels per tile
  localparam int         COL_W   = 5;      // RAM word address: {sel, row, col}
  localparam int         ROW_W   = 5;
  localparam int         ADDR_W  = 1 + ROW_W + COL_W;
  localparam int         SEL_BIT = ADDR_W - 1;

  typedef enum logic [2:0] {
    IDLE, RDC, RDA, PEND, ISSUE, WAIT1, DONE
  } scan_st_t;

  function automatic logic [ADDR_W-1:0] tile_addr(input logic sel,
      input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return {sel, row, col};
  endfunction
endpackage

// File: rtl/jtkiwi_tilescan_fetch.sv
// Reads one tile (code word, then attr word) from tile RAM into a shadow
// register. The attr word is forwarded straight from the RAM in its arrival cycle.
module jtkiwi_tilescan_fetch
  import jtkiwi_tilescan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_row,
  input  logic [COL_W-1:0]  i_col,
  input  logic              i_take,
  output logic [ADDR_W-1:0] o_vram_addr,
  input  logic [15:0]       i_vram_dout,
  output logic              o_vld,
  output logic [15:0]       o_code,
  output logic [15:0]       o_attr
);
  logic [1:0]        r_ph;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_code, r_attr;
  logic              r_vld;

  assign o_vram_addr = r_addr;
  assign o_code      = r_code;
  assign o_vld       = r_vld | (r_ph == 2'd3);
  assign o_attr      = (r_ph == 2'd3) ? i_vram_dout : r_attr;

  // r_ph: 1 code address out, 2 attr address out / code on bus, 3 attr on bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ph   <= 2'd0;
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
      r_code <= '0;
      r_attr <= '0;
      r_vld  <= 1'b0;
    end else begin
      if (r_ph == 2'd2) r_code <= i_vram_dout;
      if (r_ph == 2'd3) r_attr <= i_vram_dout;
      if (i_clr || i_take) r_vld <= 1'b0;
      else if (r_ph == 2'd3) r_vld <= 1'b1;
      if (i_start) begin
        r_addr <= tile_addr(1'b0, i_row, i_col);
        r_row  <= i_row;
        r_col  <= i_col;
        r_ph   <= 2'd1;
      end else if (i_clr) begin
        r_ph <= 2'd0;
      end else begin
        case (r_ph)
          2'd1: begin
            r_addr <= tile_addr(1'b1, r_row, r_col);
            r_ph   <= 2'd2;
          end
          2'd2:    r_ph <= 2'd3;
          default: r_ph <= 2'd0;
        endcase
      end
    end
  end
endmodule

// File: rtl/jtkiwi_tilescan.sv
// Tile layer line scanner: on each hs edge walks the 32 visible tiles of the
// line, prefetching tile i+1 while the drawer is busy with tile i.
module jtkiwi_tilescan
  import jtkiwi_tilescan_pkg::*;
(
  input  logic              rst,
  input  logic              clk,
  input  logic              hs,
  input  logic [8:0]        vrender,
  input  logic              en,
  input  logic [8:0]        scrx,
  input  logic [8:0]        scry,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [15:0]       vram_dout,
  output logic              draw,
  input  logic              busy,
  output logic [15:0]       code,
  output logic [15:0]       attr,
  output logic [8:0]        xpos,
  output logic [3:0]        ysub,
  output logic              done
);
  scan_st_t         r_st;
  logic             r_hs_d, r_en;
  logic [ROW_W-1:0] r_row;
  logic [3:0]       r_ysub_l;
  logic [8:0]       r_scrx;
  logic [5:0]       r_cnt;

  logic [8:0]       w_sum, w_xpos;
  logic             w_edge, w_issue, w_start, w_vld;
  logic [ROW_W-1:0] w_frow;
  logic [COL_W-1:0] w_fcol;
  logic [15:0]      w_code, w_attr;

  assign w_sum   = vrender + scry;
  assign w_edge  = hs & ~r_hs_d;
  assign w_issue = (r_st == PEND) && !w_edge && r_en && (r_cnt < NTILES) && w_vld && !busy;
  assign w_start = (w_edge & en) | (w_issue && (r_cnt < NTILES - 6'd1));
  assign w_frow  = w_edge ? w_sum[8:4] : r_row;
  assign w_fcol  = w_edge ? scrx[8:4] : r_cnt[4:0] + 5'd1 + r_scrx[8:4];
  assign w_xpos  = {r_cnt[4:0], 4'd0} - {5'd0, r_scrx[3:0]};

  jtkiwi_tilescan_fetch u_fetch (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_edge),
    .i_start     (w_start),
    .i_row       (w_frow),
    .i_col       (w_fcol),
    .i_take      (w_issue),
    .o_vram_addr (vram_addr),
    .i_vram_dout (vram_dout),
    .o_vld       (w_vld),
    .o_code      (w_code),
    .o_attr      (w_attr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= IDLE;
      r_hs_d   <= 1'b1;  // an hs already high when reset drops is not a new line
      r_en     <= 1'b0;
      r_row    <= '0;
      r_ysub_l <= '0;
      r_scrx   <= '0;
      r_cnt    <= '0;
      draw     <= 1'b0;
      done     <= 1'b0;
      code     <= '0;
      attr     <= '0;
      xpos     <= '0;
      ysub     <= '0;
    end else begin
      r_hs_d <= hs;
      if (w_edge) begin
        r_row    <= w_sum[8:4];
        r_ysub_l <= w_sum[3:0];
        r_scrx   <= scrx;
        r_en     <= en;
        r_cnt    <= '0;
        draw     <= 1'b0;
        done     <= 1'b0;
        r_st     <= en ? RDC : DONE;
      end else begin
        case (r_st)
          RDC: r_st <= RDA;
          RDA: r_st <= PEND;
          PEND: begin
            if (r_cnt == NTILES) begin
              if (!busy) begin
                done <= 1'b1;
                r_st <= DONE;
              end
            end else if (w_issue) begin
              draw  <= 1'b1;
              code  <= w_code;
              attr  <= w_attr;
              xpos  <= w_xpos;
              ysub  <= r_ysub_l;
              r_cnt <= r_cnt + 6'd1;
              r_st  <= ISSUE;
            end
          end
          ISSUE: begin
            draw <= 1'b0;
            r_st <= WAIT1;
          end
          WAIT1:   r_st <= PEND;  // drawer's busy is not valid yet
          DONE:    done <= 1'b1;
          default: r_st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtkiwi_tilescan.sv
// Scoreboard bench for jtkiwi_tilescan: a RAM and drawer model drive the DUT,
// expected tiles are queued per line and popped by a monitor on each draw.
module tb_jtkiwi_tilescan;
  logic        clk = 1'b0;
  logic        rst, hs, en, busy, draw, done;
  logic [8:0]  vrender, scrx, scry, xpos;
  logic [10:0] vram_addr;
  logic [15:0] vram_dout, code, attr;
  logic [3:0]  ysub;

  typedef struct packed {
    logic [15:0] code;
    logic [15:0] attr;
    logic [8:0]  xpos;
    logic [3:0]  ysub;
  } tile_t;

  tile_t       sb[$];
  tile_t       hold, first_t, last_t;
  logic [15:0] mem[2048];
  int          checks = 0, failures = 0;
  int          cyc = 0, edge_cyc = 0, fall_cyc = 0, prev_cyc = -100;
  int          blen = 0, line_draws = 0;
  bit          fall_vld = 0, lat_chk = 0, have_hold = 0;

  jtkiwi_tilescan dut (
    .rst(rst), .clk(clk), .hs(hs), .vrender(vrender), .en(en),
    .scrx(scrx), .scry(scry), .vram_addr(vram_addr), .vram_dout(vram_dout),
    .draw(draw), .busy(busy), .code(code), .attr(attr), .xpos(xpos),
    .ysub(ysub), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) vram_dout <= mem[vram_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] word(input logic sel, input logic [4:0] row, input logic [4:0] col);
    return 16'hA800 | {5'd0, sel, row, col};
  endfunction

  task automatic push_line(input logic [8:0] vr, input logic [8:0] sx, input logic [8:0] sy);
    logic [8:0] s;
    logic [4:0] mc;
    tile_t      t;
    s = vr + sy;
    for (int i = 0; i < 32; i++) begin
      mc     = 5'(i) + sx[8:4];
      t.code = word(1'b0, s[8:4], mc);
      t.attr = word(1'b1, s[8:4], mc);
      t.xpos = 9'(i * 16) - {5'd0, sx[3:0]};
      t.ysub = s[3:0];
      sb.push_back(t);
    end
  endtask

  // drawer: samples draw, raises busy one cycle later and holds it blen cycles
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (draw && !rst && blen > 0) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        busy = 1'b1;
        for (int k = 0; k < blen && !rst; k++) begin
          @(posedge clk); #1;
        end
        busy     = 1'b0;
        fall_cyc = cyc;
        fall_vld = 1'b1;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      have_hold = 1'b0;
    end else if (draw) begin
      if (sb.size() == 0) begin
        chk("unexpected_draw", 64'(draw), 64'(0));
      end else begin
        chk("tile", 64'(tile_t'({code, attr, xpos, ysub})), 64'(sb.pop_front()));
      end
      chk("draw_while_busy", 64'(busy), 64'(0));
      if (cyc - prev_cyc < 3) chk("issue_gap", 64'(cyc - prev_cyc), 64'(3));
      if (lat_chk) chk("first_latency", 64'(cyc), 64'(edge_cyc + 3));
      if (fall_vld && blen >= 3) chk("draw_after_busy", 64'(cyc), 64'(fall_cyc + 1));
      lat_chk   = 1'b0;
      fall_vld  = 1'b0;
      prev_cyc  = cyc;
      hold      = {code, attr, xpos, ysub};
      have_hold = 1'b1;
      if (line_draws == 0) first_t = hold;
      last_t = hold;
      line_draws++;
    end else if (busy && have_hold) begin
      chk("stable_busy", 64'(tile_t'({code, attr, xpos, ysub})), 64'(hold));
    end
  end

  task automatic start_line(input logic [8:0] vr, input logic [8:0] sx, input logic [8:0] sy,
                            input logic e, input int bl, input bit lat, input logic [10:0] a0);
    @(negedge clk);
    vrender = vr; scrx = sx; scry = sy; en = e; blen = bl;
    if (e) push_line(vr, sx, sy);
    line_draws = 0; fall_vld = 1'b0;
    edge_cyc = cyc + 1; lat_chk = lat;
    hs = 1'b1;
    @(negedge clk);
    chk("done_cleared", 64'(done), 64'(0));
    if (e) chk("first_addr", 64'(vram_addr), 64'(a0));
    @(negedge clk);
    chk("done_next", 64'(done), 64'(!e));
    @(negedge clk);
    hs = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(done && sb.size() == 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(done), 64'(1));
    chk({nm, "_draws"}, 64'(line_draws), 64'(32));
  endtask

  task automatic wait_draws(input int nd);
    int n = 0;
    while (line_draws < nd && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("draw_count_reached", 64'(line_draws >= nd), 64'(1));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_draw"}, 64'(draw), 64'(0));
    chk({nm, "_done"}, 64'(done), 64'(0));
    chk({nm, "_tile"}, 64'(tile_t'({code, attr, xpos, ysub})), 64'(0));
    chk({nm, "_addr"}, 64'(vram_addr), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 16'hA800 | 16'(a);
    rst = 1'b1; hs = 1'b0; en = 1'b0; vrender = '0; scrx = '0; scry = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // plain line, drawer busy 20 cycles
    start_line(9'd5, 9'd0, 9'd0, 1'b1, 20, 1, 11'h000);
    wait_done("line_plain");
    chk("plain_first", 64'(first_t), 64'(tile_t'({16'hA800, 16'hAC00, 9'd0, 4'd5})));
    chk("plain_last", 64'(last_t), 64'(tile_t'({16'hA81F, 16'hAC1F, 9'd496, 4'd5})));

    // fine + coarse horizontal scroll
    start_line(9'd5, 9'h013, 9'd0, 1'b1, 3, 1, 11'h001);
    wait_done("line_scrx");
    chk("scrx_first", 64'(first_t), 64'(tile_t'({16'hA801, 16'hAC01, 9'h1FD, 4'd5})));
    chk("scrx_last", 64'(last_t), 64'(tile_t'({16'hA800, 16'hAC00, 9'h1ED, 4'd5})));

    // vertical scroll wrap, drawer never busy
    start_line(9'h010, 9'd0, 9'h1F8, 1'b1, 0, 1, 11'h000);
    wait_done("line_scry");
    chk("scry_ysub", 64'(first_t.ysub), 64'(8));

    // long busy: outputs held, next tile prefetched
    start_line(9'h025, 9'h020, 9'd0, 1'b1, 50, 1, 11'h042);
    wait_done("line_busy50");
    chk("busy50_first", 64'(first_t), 64'(tile_t'({16'hA842, 16'hAC42, 9'd0, 4'd5})));

    // hs injected mid-line while the drawer is busy
    start_line(9'h030, 9'd0, 9'd0, 1'b1, 20, 1, 11'h060);
    wait_draws(11);
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    chk("abort_busy_seen", 64'(busy), 64'(1));
    sb.delete();
    start_line(9'h05A, 9'd0, 9'd0, 1'b1, 20, 0, 11'h0A0);
    wait_done("line_abort");
    chk("abort_first", 64'(first_t), 64'(tile_t'({16'hA8A0, 16'hACA0, 9'd0, 4'hA})));

    // layer disabled
    start_line(9'd5, 9'd0, 9'd0, 1'b0, 20, 0, 11'h000);
    repeat (20) @(negedge clk);
    chk("disabled_draws", 64'(line_draws), 64'(0));
    chk("disabled_done", 64'(done), 64'(1));

    // reset mid-scan
    start_line(9'd5, 9'd0, 9'd0, 1'b1, 5, 1, 11'h000);
    wait_draws(5);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk_zero("after_rst");
    chk("after_rst_draws", 64'(line_draws), 64'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtkiwi_tilescan.md
JTKIWI_TILESCAN -- requirements
Module: jtkiwi_tilescan

Interface
REQ-001 SHALL have reset rst, asynchronous, active-high, and clock clk.
REQ-002 rst  in  1  async active-high reset; clk  in  1  system clock.
REQ-003 hs  in  1  horizontal sync; a rising edge starts the scan of one line.
REQ-004 vrender  in  9  line being prepared; en  in  1  layer enable, sampled at the hs edge.
REQ-005 scrx  in  9  horizontal scroll; scry  in  9  vertical scroll; both sampled at the hs edge.
REQ-006 vram_addr  out  11  tile RAM word address; vram_dout  in  16  read data, fixed 1-cycle latency.
REQ-007 draw  out  1  one-cycle tile draw request; busy  in  1  tile drawer busy flag.
REQ-008 code  out  16, attr  out  16, xpos  out  9, ysub  out  4: tile command fields.
REQ-009 done  out  1  high from the end of a line scan until the next hs edge.

Function
REQ-010 SHALL detect the hs rising edge by comparing hs with a one-cycle-delayed copy.
REQ-011 At the hs edge: latch row = (vrender+scry)[8:4], ysub_l = (vrender+scry)[3:0], scrx, en; clear column counter i; clear done.
REQ-012 Map column mc = i + scrx[8:4], 5-bit wrap; tile xpos = {i,4'd0} - scrx[3:0], 9-bit wrap.
REQ-013 Code word address = {1'b0,row,mc}; attr word address = {1'b1,row,mc}.
REQ-014 States: IDLE, RDC (code address out), RDA (attr address out, code captured), PEND (attr captured; prefetched tile held), ISSUE, WAIT1, DONE.
REQ-015 Prefetch: tile i+1 is read into shadow registers while the drawer is busy with tile i.
REQ-016 code/attr/xpos/ysub outputs SHALL change only in the cycle draw is asserted, and SHALL stay stable while busy is high.
REQ-017 ISSUE: draw=1 for exactly one cycle, only when busy=0 and a prefetched tile is held; outputs load from the shadow registers.
REQ-018 WAIT1: busy is ignored in the cycle after draw, because the drawer raises busy one cycle after sampling draw.
REQ-019 32 tiles per line, i=0..31; after tile 31 is issued and busy returns low, go to DONE with done=1.
REQ-020 An hs edge in any state aborts the current scan and restarts from column 0; a pending draw pulse is not issued in that cycle.
REQ-021 An hs edge arriving while busy=1 SHALL NOT change the outputs until busy=0.
REQ-022 en=0 at the hs edge: no reads, no draws; done=1 at the next cycle.
REQ-023 Timing: with busy=0, hs edge seen at cycle N gives draw at cycle N+3 for tile 0.
REQ-024 Throughput: when busy is held low by the drawer, tiles are issued no faster than one every 3 cycles.
REQ-025 vram_addr holds its last value when no read is in progress.

Reset
REQ-026 Reset values: draw=0, done=0, code=0, attr=0, xpos=0, ysub=0, vram_addr=0, state=IDLE, i=0, shadow registers cleared.
REQ-027 Reset mid-scan SHALL abandon the line; no draw is issued until the next hs edge after rst falls.

Structure
REQ-028 Tile-count (32), tile width (16) and RAM layout bit positions SHALL be localparams in a shared jtkiwi package, used by both scanner and drawer.
REQ-029 A single sub-module, jtkiwi_tilescan_fetch (RAM address sequencing plus the shadow register), is natural; the state machine stays in the top level.

Verification
REQ-030 en=1, scrx=0, scry=0, vrender=5, busy model = 20 cycles: 32 draws, xpos=0,16,...,496, ysub=5, code address row 0, then done=1.
REQ-031 scrx=0x013: tile 0 reads mc=1 with xpos=0x1FD; tile 31 reads mc=0 with xpos=0x1ED.
REQ-032 scry=0x1F8, vrender=0x010: row=0, ysub=8 (9-bit wrap); vram_addr of first read = 0x000.
REQ-033 Drawer holds busy for 50 cycles: code/attr/xpos/ysub constant throughout; the next draw comes 1 cycle after busy falls, the tile already prefetched.
REQ-034 hs edge injected after tile 10 while busy=1: no draw until busy=0; the next draw has xpos for column 0 and the new row.
REQ-035 en=0: zero draws, done=1 at N+1; rst pulsed mid-scan: draw=0 and all outputs zero until the next hs edge.
